hd_classify_ctrl: RTL and testbench
===================================

Name: hd_classify_ctrl

Overview:
Synthesizable sequencer for hyperdimensional_module (HD encoder plus associative search). It accepts a symbol stream through a valid/ready handshake and maps it onto letterReady/inputLetter. It then issues textDone and computeAngle pulses, sweeps the hypervector index 0..N-1, asserts argmax, and waits for done. The classification result (bestMatchID) is returned on a valid/ready result port. It replaces the behavioural test-file FSM so the classifier can run standalone behind a host or UART front end.

Parameters:
N, 10000, hypervector dimension
PRECISION, $clog2(N), index width
MAXLETTERS, 10, alphabet size; legal symbols are 0..MAXLETTERS-1
NUMLANG, 10, number of classes
LOG_NUMLANG, $clog2(NUMLANG), class ID width
SETTLE_CYCLES, 2, idle cycles between end of sweep and sampling done
WAIT_MAX, 1024, cycle limit for done before timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
sym_valid  in  1  symbol valid
sym_ready  out  1  symbol accepted this cycle when sym_valid is also high
sym_data  in  5  symbol code
sym_last  in  1  marks the final symbol of a text
letterReady  out  1  to HD: inputLetter valid
inputLetter  out  5  to HD: symbol
textDone  out  1  to HD: threshold/finalize pulse
rst_RI  out  1  to HD: encoder run, active-high; 0 clears encoder state
computeAngle  out  1  to HD: start-search pulse
index  out  PRECISION  to HD: component pointer
argmax  out  1  to HD: compute final minimum
done  in  1  from HD: search complete
bestMatchID  in  LOG_NUMLANG  from HD: winning class
res_valid  out  1  result valid
res_ready  in  1  result consumed
res_class  out  LOG_NUMLANG  classified ID (0 when res_err=1)
res_err  out  1  timeout flag
drop_cnt  out  16  illegal symbols dropped since reset (saturating)

Behaviour:
- Reset (rst=0 at a clk edge): state goes to IDLE. All outputs are 0, including index, drop_cnt, res_*. A reset mid-operation aborts the text; no partial result is produced.
- All outputs are registered. sym_ready is combinational from state: 1 in IDLE and LOAD only.
- IDLE: rst_RI=0. On the first accept, set rst_RI=1 and go to LOAD; that symbol is processed as in LOAD.
- LOAD: each accept of a legal symbol (sym_data<MAXLETTERS) gives letterReady=1 and inputLetter=sym_data in the next cycle. An illegal symbol gives letterReady=0 and drop_cnt+1, saturating at 0xFFFF. With no accept, letterReady=0. An accept with sym_last=1, legal or not, goes to FLUSH.
- FLUSH: 1 cycle, textDone=1, sym_ready=0.
- START: 1 cycle, computeAngle=1, index=0.
- SWEEP: index increments by 1 per cycle, starting at 0 in the first SWEEP cycle and ending at N-1, for exactly N cycles. computeAngle=0, argmax=0. After the index=N-1 cycle, set argmax=1 and hold it through SETTLE and WAIT.
- SETTLE: SETTLE_CYCLES cycles; done is ignored.
- WAIT: sample done each cycle.
  - When done=1: capture bestMatchID into res_class, set res_err=0, res_valid=1, argmax=0, and go to RESULT.
  - After WAIT_MAX cycles without done: res_err=1, res_class=0, res_valid=1, argmax=0, go to RESULT.
- RESULT: res_valid is held with stable payload until res_ready=1. On the handshake, res_valid=0, rst_RI=0, and state goes to IDLE. If res_ready is already high when res_valid rises, that cycle completes the handshake.
- Back-pressure: the sym_valid rising edge may arrive in any state; symbols wait outside IDLE/LOAD.
- Single-symbol text (sym_last on the first accept): IDLE, then FLUSH directly after that symbol's letterReady cycle.
- Latency from the sym_last accept to res_valid: 1 + 1 + N + SETTLE_CYCLES + (cycles to done), with done sampled no earlier than the first WAIT cycle.
- index width arithmetic: the compare is index==N-1, so there is no wrap. index holds N-1 outside SWEEP until the next START.

Decomposition:
- Package hd_pkg holds:
  - the state enum: IDLE, LOAD, FLUSH, START, SWEEP, SETTLE, WAIT, RESULT;
  - the N/MAXLETTERS/NUMLANG defaults;
  - the SYM_W=5 constant.
- One sub-module, hd_sweep_counter: index counter with start, done-at-terminal and hold. It is reused by the training controller.

Test Plan (bench N=16, SETTLE_CYCLES=2, WAIT_MAX=32, HD behavioural model):
1. Symbols 3,9,0 (last) with sym_valid held high: letterReady pulses carry inputLetter 3,9,0 on consecutive cycles. Then come one textDone pulse, one computeAngle pulse, and index 0..15 over 16 cycles. argmax rises after index=15. The model raises done with ID 7: res_valid=1, res_class=7, res_err=0.
2. Stream 2,12,31,4 (last): letterReady only for 2 and 4, drop_cnt=2, result still produced.
3. res_ready held low for 10 cycles after res_valid: payload stable, sym_ready=0 throughout, a new text is accepted only after the handshake.
4. The model never asserts done: exactly 32 WAIT cycles, then res_valid=1, res_err=1, res_class=0, argmax drops to 0.
5. rst driven low during SWEEP at index=5: next cycle all outputs are 0 and state is IDLE. The next text runs cleanly with index starting at 0.
6. Single symbol 1 with sym_last: one letterReady pulse, then textDone the next cycle, then the full sequence. rst_RI=0 again after the result handshake.

Source files
------------

// File: rtl/hd_pkg.sv
// Shared types and defaults for the HD classifier sequencer and its siblings.
package hd_pkg;

  localparam int unsigned N_DEFAULT          = 10000;
  localparam int unsigned MAXLETTERS_DEFAULT = 10;
  localparam int unsigned NUMLANG_DEFAULT    = 10;
  localparam int unsigned SYM_W              = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    START,
    SWEEP,
    SETTLE,
    WAIT,
    RESULT
  } hd_state_e;

endpackage

// File: rtl/hd_classify_ctrl_if.sv
// Host-side symbol stream and result handshake of the HD classifier sequencer.
interface hd_classify_ctrl_if #(
  parameter int unsigned CLASS_W = 4
) ();

  logic                      sym_valid;
  logic                      sym_ready;
  logic [hd_pkg::SYM_W-1:0]  sym_data;
  logic                      sym_last;
  logic                      res_valid;
  logic                      res_ready;
  logic [CLASS_W-1:0]        res_class;
  logic                      res_err;

  modport master (
    output sym_valid, sym_data, sym_last, res_ready,
    input  sym_ready, res_valid, res_class, res_err
  );

  modport slave (
    input  sym_valid, sym_data, sym_last, res_ready,
    output sym_ready, res_valid, res_class, res_err
  );

endinterface

// File: rtl/hd_sweep_counter.sv
// Hypervector component pointer: loads 0 on start, steps on en, holds at N-1.
module hd_sweep_counter #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  output logic [W-1:0] index,
  output logic         at_end
);

  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] index_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      index_q <= '0;
    end else if (start) begin
      index_q <= '0;
    end else if (en && (index_q != Last)) begin
      index_q <= index_q + W'(1);
    end
  end

  assign index  = index_q;
  assign at_end = (index_q == Last);

endmodule

// File: rtl/hd_classify_ctrl.sv
// Standalone sequencer driving hyperdimensional_module: letter load, finalize, sweep, argmax, result.
module hd_classify_ctrl
  import hd_pkg::*;
#(
  parameter int unsigned N             = N_DEFAULT,
  parameter int unsigned PRECISION     = $clog2(N),
  parameter int unsigned MAXLETTERS    = MAXLETTERS_DEFAULT,
  parameter int unsigned NUMLANG       = NUMLANG_DEFAULT,
  parameter int unsigned LOG_NUMLANG   = $clog2(NUMLANG),
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned WAIT_MAX      = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  hd_classify_ctrl_if.slave      host,
  output logic                   letterReady,
  output logic [SYM_W-1:0]       inputLetter,
  output logic                   textDone,
  output logic                   rst_RI,
  output logic                   computeAngle,
  output logic [PRECISION-1:0]   index,
  output logic                   argmax,
  input  logic                   done,
  input  logic [LOG_NUMLANG-1:0] bestMatchID,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned TmrMax = (WAIT_MAX > SETTLE_CYCLES) ? WAIT_MAX : SETTLE_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [TmrW-1:0] WaitLast   = TmrW'(WAIT_MAX - 1);

  hd_state_e state_q, state_d;

  logic                   letter_ready_q, letter_ready_d;
  logic [SYM_W-1:0]       input_letter_q, input_letter_d;
  logic                   text_done_q, text_done_d;
  logic                   rst_ri_q, rst_ri_d;
  logic                   compute_angle_q, compute_angle_d;
  logic                   argmax_q, argmax_d;
  logic                   res_valid_q, res_valid_d;
  logic [LOG_NUMLANG-1:0] res_class_q, res_class_d;
  logic                   res_err_q, res_err_d;
  logic [15:0]            drop_q, drop_d;
  logic [TmrW-1:0]        tmr_q, tmr_d;

  logic cnt_start, cnt_en, cnt_at_end;
  logic sym_ready_w, accept, legal;

  // Gated by rst so the port also reads 0 while reset is held.
  assign sym_ready_w = rst & ((state_q == IDLE) | (state_q == LOAD));
  assign accept      = host.sym_valid & sym_ready_w;
  assign legal       = ({{(32 - SYM_W){1'b0}}, host.sym_data} < MAXLETTERS);

  hd_sweep_counter #(
    .N (N),
    .W (PRECISION)
  ) u_sweep (
    .clk    (clk),
    .rst    (rst),
    .start  (cnt_start),
    .en     (cnt_en),
    .index  (index),
    .at_end (cnt_at_end)
  );

  always_comb begin
    state_d         = state_q;
    letter_ready_d  = 1'b0;
    input_letter_d  = input_letter_q;
    text_done_d     = 1'b0;
    compute_angle_d = 1'b0;
    argmax_d        = argmax_q;
    rst_ri_d        = rst_ri_q;
    res_valid_d     = res_valid_q;
    res_class_d     = res_class_q;
    res_err_d       = res_err_q;
    drop_d          = drop_q;
    tmr_d           = tmr_q;
    cnt_start       = 1'b0;
    cnt_en          = 1'b0;

    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          rst_ri_d = 1'b1;
          if (legal) begin
            letter_ready_d = 1'b1;
            input_letter_d = host.sym_data;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
          state_d = host.sym_last ? FLUSH : LOAD;
        end
      end
      FLUSH: begin
        text_done_d = 1'b1;
        state_d     = START;
      end
      START: begin
        compute_angle_d = 1'b1;
        cnt_start       = 1'b1;
        state_d         = SWEEP;
      end
      SWEEP: begin
        // Index 0 is presented twice: with computeAngle, then as the first sweep step.
        cnt_en = ~compute_angle_q;
        if (cnt_at_end && !compute_angle_q) begin
          argmax_d = 1'b1;
          tmr_d    = '0;
          state_d  = (SETTLE_CYCLES == 0) ? WAIT : SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_q == SettleLast) begin
          tmr_d   = '0;
          state_d = WAIT;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      WAIT: begin
        if (done) begin
          res_class_d = bestMatchID;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          argmax_d    = 1'b0;
          state_d     = RESULT;
        end else if (tmr_q == WaitLast) begin
          res_class_d = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          argmax_d    = 1'b0;
          state_d     = RESULT;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      RESULT: begin
        if (host.res_ready) begin
          res_valid_d = 1'b0;
          rst_ri_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      letter_ready_q  <= 1'b0;
      input_letter_q  <= '0;
      text_done_q     <= 1'b0;
      rst_ri_q        <= 1'b0;
      compute_angle_q <= 1'b0;
      argmax_q        <= 1'b0;
      res_valid_q     <= 1'b0;
      res_class_q     <= '0;
      res_err_q       <= 1'b0;
      drop_q          <= '0;
      tmr_q           <= '0;
    end else begin
      state_q         <= state_d;
      letter_ready_q  <= letter_ready_d;
      input_letter_q  <= input_letter_d;
      text_done_q     <= text_done_d;
      rst_ri_q        <= rst_ri_d;
      compute_angle_q <= compute_angle_d;
      argmax_q        <= argmax_d;
      res_valid_q     <= res_valid_d;
      res_class_q     <= res_class_d;
      res_err_q       <= res_err_d;
      drop_q          <= drop_d;
      tmr_q           <= tmr_d;
    end
  end

  assign host.sym_ready = sym_ready_w;
  assign host.res_valid = res_valid_q;
  assign host.res_class = res_class_q;
  assign host.res_err   = res_err_q;
  assign letterReady    = letter_ready_q;
  assign inputLetter    = input_letter_q;
  assign textDone       = text_done_q;
  assign rst_RI         = rst_ri_q;
  assign computeAngle   = compute_angle_q;
  assign argmax         = argmax_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_hd_classify_ctrl.sv
// Directed bench for hd_classify_ctrl with N=16, SETTLE_CYCLES=2, WAIT_MAX=32 and a scripted HD model.
module tb_hd_classify_ctrl;

  localparam int unsigned N    = 16;
  localparam int unsigned PREC = 4;
  localparam int unsigned CLW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           done;
  logic [CLW-1:0] best;
  logic           letterReady, textDone, rst_RI, computeAngle, argmax;
  logic [4:0]     inputLetter;
  logic [PREC-1:0] index;
  logic [15:0]    drop_cnt;

  int checks = 0;
  int passed = 0;

  hd_classify_ctrl_if #(.CLASS_W(CLW)) hif ();

  hd_classify_ctrl #(
    .N             (N),
    .PRECISION     (PREC),
    .MAXLETTERS    (10),
    .NUMLANG       (10),
    .LOG_NUMLANG   (CLW),
    .SETTLE_CYCLES (2),
    .WAIT_MAX      (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (hif),
    .letterReady  (letterReady),
    .inputLetter  (inputLetter),
    .textDone     (textDone),
    .rst_RI       (rst_RI),
    .computeAngle (computeAngle),
    .index        (index),
    .argmax       (argmax),
    .done         (done),
    .bestMatchID  (best),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [36:0] outs;
  assign outs = {letterReady, inputLetter, textDone, rst_RI, computeAngle, index, argmax,
                 hif.res_valid, hif.res_class, hif.res_err, drop_cnt, hif.sym_ready};

  // Trace of one text, with rel = cycles after the sym_last accept edge.
  int sym_q[$];
  int lr_val[$];
  int lr_cyc[$];
  int idx_at[64];
  int td_cnt, td_rel, ca_cnt, ca_rel, ca_idx, am_first, am_total;
  int rv_cnt, rv_rel, rv_class, rv_err, rv_am, ri_mid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_text(input int done_delay, input logic [CLW-1:0] done_id,
                          input logic auto_ready);
    int sp, base, rel, am_cnt;
    logic acc, finished;
    lr_val.delete();
    lr_cyc.delete();
    for (int i = 0; i < 64; i++) idx_at[i] = -1;
    td_cnt = 0; td_rel = -1; ca_cnt = 0; ca_rel = -1; ca_idx = -1; am_first = -1;
    rv_cnt = 0; rv_rel = -1; rv_class = -1; rv_err = -1; rv_am = -1; ri_mid = -1;
    sp = 0; base = -1; am_cnt = 0; finished = 1'b0;
    hif.sym_data  = 5'(sym_q[0]);
    hif.sym_last  = (sym_q.size() == 1);
    hif.sym_valid = 1'b1;
    hif.res_ready = auto_ready;
    done = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      acc = hif.sym_valid && hif.sym_ready;
      tick();
      if (acc) begin
        if (sp == sym_q.size() - 1) begin
          base = c;
          hif.sym_valid = 1'b0;
          hif.sym_last  = 1'b0;
        end else begin
          sp++;
          hif.sym_data = 5'(sym_q[sp]);
          hif.sym_last = (sp == sym_q.size() - 1);
        end
      end
      rel = (base >= 0) ? c - base : -1;
      if (letterReady) begin
        lr_val.push_back(int'(inputLetter));
        lr_cyc.push_back(c);
      end
      if (textDone) begin td_cnt++; td_rel = rel; end
      if (computeAngle) begin ca_cnt++; ca_rel = rel; ca_idx = int'(index); end
      if (rel >= 0 && rel < 64) idx_at[rel] = int'(index);
      if (rel == 2) ri_mid = int'(rst_RI);
      if (argmax) begin
        am_cnt++;
        if (am_first < 0) am_first = rel;
      end
      if (done_delay >= 0 && argmax && am_cnt == done_delay) begin
        done = 1'b1;
        best = done_id;
      end
      if (hif.res_valid) begin
        if (rv_cnt == 0) begin
          rv_rel = rel; rv_class = int'(hif.res_class);
          rv_err = int'(hif.res_err); rv_am = int'(argmax);
        end
        rv_cnt++;
        done = 1'b0;
        if (!auto_ready) finished = 1'b1;
      end else if (rv_cnt > 0) begin
        finished = 1'b1;
      end
    end
    am_total = am_cnt;
    done = 1'b0;
    checks++;
    if (!finished) $display("FAIL run_text_bound: got rv_cnt=%0d, required completion in 200 cycles",
                            rv_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hif.sym_valid = 1'b0; hif.sym_data = '0; hif.sym_last = 1'b0; hif.res_ready = 1'b0;
    done = 1'b0; best = '0;
    tick(); tick();
    checks++;
    if (outs !== 37'b0) $display("FAIL reset_outputs: got %h, required 0", outs);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (hif.sym_ready !== 1'b1) $display("FAIL reset_idle_ready: got %b, required 1", hif.sym_ready);
    else passed++;
  endtask

  task automatic test_basic();
    int bad;
    sym_q = '{3, 9, 0};
    run_text(3, 4'd7, 1'b1);
    checks++;
    if (lr_val.size() != 3 || lr_val[0] != 3 || lr_val[1] != 9 || lr_val[2] != 0 ||
        lr_cyc[2] - lr_cyc[0] != 2)
      $display("FAIL basic_letters: got %p, required 3 9 0 on consecutive cycles", lr_val);
    else passed++;
    checks++;
    if (td_cnt != 1 || td_rel != 1)
      $display("FAIL basic_textdone: got count %0d rel %0d, required 1 at rel 1", td_cnt, td_rel);
    else passed++;
    checks++;
    if (ca_cnt != 1 || ca_rel != 2 || ca_idx != 0)
      $display("FAIL basic_angle: got count %0d rel %0d idx %0d, required 1 at rel 2 idx 0",
               ca_cnt, ca_rel, ca_idx);
    else passed++;
    bad = -1;
    for (int k = 0; k < N; k++) if (idx_at[3 + k] != k && bad < 0) bad = k;
    checks++;
    if (bad >= 0) $display("FAIL basic_sweep: step %0d got index %0d, required %0d",
                           bad, idx_at[3 + bad], bad);
    else passed++;
    checks++;
    if (am_first != N + 3) $display("FAIL basic_argmax_rise: got rel %0d, required %0d",
                                    am_first, N + 3);
    else passed++;
    checks++;
    if (rv_rel != N + 6 || rv_class != 7 || rv_err != 0 || rv_cnt != 1)
      $display("FAIL basic_result: got rel %0d class %0d err %0d cycles %0d, required %0d 7 0 1",
               rv_rel, rv_class, rv_err, rv_cnt, N + 6);
    else passed++;
    checks++;
    if (ri_mid != 1 || rst_RI !== 1'b0 || hif.sym_ready !== 1'b1)
      $display("FAIL basic_rst_ri: got mid %0d after %b ready %b, required 1 0 1",
               ri_mid, rst_RI, hif.sym_ready);
    else passed++;
  endtask

  task automatic test_illegal();
    sym_q = '{2, 12, 31, 4};
    run_text(3, 4'd3, 1'b1);
    checks++;
    if (lr_val.size() != 2 || lr_val[0] != 2 || lr_val[1] != 4)
      $display("FAIL illegal_letters: got %p, required 2 4", lr_val);
    else passed++;
    checks++;
    if (drop_cnt !== 16'd2) $display("FAIL illegal_drop_cnt: got %0d, required 2", drop_cnt);
    else passed++;
    checks++;
    if (idx_at[1] != N - 1) $display("FAIL illegal_index_hold: got %0d, required %0d",
                                     idx_at[1], N - 1);
    else passed++;
    checks++;
    if (rv_rel != N + 6 || rv_class != 3 || rv_err != 0)
      $display("FAIL illegal_result: got rel %0d class %0d err %0d, required %0d 3 0",
               rv_rel, rv_class, rv_err, N + 6);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    sym_q = '{6};
    run_text(3, 4'd5, 1'b0);
    checks++;
    if (rv_class != 5 || rv_err != 0) $display("FAIL bp_result: got class %0d err %0d, required 5 0",
                                               rv_class, rv_err);
    else passed++;
    hif.sym_data = 5'd7; hif.sym_last = 1'b0; hif.sym_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hif.res_valid !== 1'b1 || hif.res_class !== 4'd5 || hif.res_err !== 1'b0 ||
          hif.sym_ready !== 1'b0 || letterReady !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles, required 0", bad);
    else passed++;
    hif.res_ready = 1'b1;
    tick();
    checks++;
    if (hif.res_valid !== 1'b0 || hif.sym_ready !== 1'b1 || letterReady !== 1'b0)
      $display("FAIL bp_handshake: got valid %b ready %b lr %b, required 0 1 0",
               hif.res_valid, hif.sym_ready, letterReady);
    else passed++;
    tick();
    hif.sym_valid = 1'b0;
    checks++;
    if (letterReady !== 1'b1 || inputLetter !== 5'd7)
      $display("FAIL bp_new_text: got lr %b letter %0d, required 1 7", letterReady, inputLetter);
    else passed++;
  endtask

  task automatic test_timeout();
    sym_q = '{8};
    run_text(-1, 4'd0, 1'b1);
    checks++;
    if (am_total != 34 || rv_rel != N + 37)
      $display("FAIL timeout_wait: got argmax cycles %0d rel %0d, required 34 %0d",
               am_total, rv_rel, N + 37);
    else passed++;
    checks++;
    if (rv_err != 1 || rv_class != 0 || rv_am != 0)
      $display("FAIL timeout_result: got err %0d class %0d argmax %0d, required 1 0 0",
               rv_err, rv_class, rv_am);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic found;
    int bad;
    found = 1'b0;
    hif.res_ready = 1'b1;
    hif.sym_data = 5'd6; hif.sym_last = 1'b1; hif.sym_valid = 1'b1;
    tick();
    hif.sym_valid = 1'b0; hif.sym_last = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (index == 4'd5 && !computeAngle) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL midrst_reach: got no index 5 in 40 cycles, required sweep");
    else passed++;
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== 37'b0) $display("FAIL midrst_outputs: got %h, required 0", outs);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (hif.sym_ready !== 1'b1) $display("FAIL midrst_idle: got ready %b, required 1",
                                         hif.sym_ready);
    else passed++;
    sym_q = '{4};
    run_text(3, 4'd2, 1'b1);
    bad = -1;
    for (int k = 0; k < N; k++) if (idx_at[3 + k] != k && bad < 0) bad = k;
    checks++;
    if (bad >= 0 || ca_idx != 0)
      $display("FAIL midrst_sweep: got bad step %0d start idx %0d, required none 0", bad, ca_idx);
    else passed++;
    checks++;
    if (rv_class != 2 || rv_err != 0) $display("FAIL midrst_result: got %0d %0d, required 2 0",
                                               rv_class, rv_err);
    else passed++;
  endtask

  task automatic test_single();
    sym_q = '{1};
    run_text(4, 4'd9, 1'b1);
    checks++;
    if (lr_val.size() != 1 || lr_val[0] != 1 || td_rel != 1 || td_cnt != 1)
      $display("FAIL single_seq: got letters %p textDone rel %0d, required 1 then rel 1",
               lr_val, td_rel);
    else passed++;
    checks++;
    if (rv_rel != N + 7 || rv_class != 9 || rv_err != 0)
      $display("FAIL single_result: got rel %0d class %0d err %0d, required %0d 9 0",
               rv_rel, rv_class, rv_err, N + 7);
    else passed++;
    checks++;
    if (rst_RI !== 1'b0) $display("FAIL single_rst_ri: got %b, required 0", rst_RI);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_single();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
